audio_timer_sched: RTL and testbench
====================================

Name: audio_timer_sched

Overview:
Avalon-MM master that owns and sequences the audio Nios interval timer (16-bit register map: status 0, control 1, period_l 2, period_h 3, snap_l 4, snap_h 5). It programs the period from a divider, starts the timer in continuous mode with interrupt enabled, services the timer irq, and emits a one-cycle sample tick with a running tick count. It also performs atomic snapshot reads of the timer phase for the audio path.

Parameters:
DEFAULT_DIVIDER, 1000000, divider loaded by the AUTO_START sequence; clk cycles per tick, must be ≥16.
AUTO_START, 0, 1 = run the load sequence with DEFAULT_DIVIDER immediately after reset.

Ports:
clk  in  1  system clock; the only clock.
reset  in  1  synchronous, active-high reset.
cfg_divider  in  32  requested tick period in clk cycles; valid range ≥16.
cfg_load  in  1  request: program cfg_divider and start the timer.
stop_req  in  1  request: stop the timer.
phase_req  in  1  request: snapshot and read the timer counter.
busy  out  1  high in every state except IDLE and RUN.
running  out  1  high in RUN and in any phase read entered from RUN.
tick  out  1  one-cycle pulse per serviced timer timeout.
tick_count  out  16  ticks since the last accepted load; wraps.
phase  out  32  last captured timer counter value.
phase_valid  out  1  one-cycle pulse when phase is updated.
err_divider  out  1  sticky: a cfg_load with cfg_divider <16 was rejected.
avm_address  out  3  timer register address.
avm_chipselect  out  1  timer select.
avm_write_n  out  1  active-low write strobe.
avm_writedata  out  16  write data.
avm_readdata  in  16  timer read data, registered one cycle after address.
timer_irq  in  1  timer interrupt, level, sticky until status is written.

Behaviour:
- Reset (synchronous, active-high): FSM IDLE; outputs 0 except avm_write_n=1; tick_count=0; phase=0; err_divider=0.
- Avalon write: one cycle with chipselect=1, write_n=0. Avalon read: one cycle with chipselect=1, write_n=1; avm_readdata is sampled in the following cycle. There is no waitrequest. Idle bus: chipselect=0, write_n=1, address=0, writedata=0.
- Requests are sampled only in IDLE or RUN. A request arriving while busy=1 is ignored.
- Priority in RUN: timer_irq > stop_req > cfg_load > phase_req. Priority in IDLE: stop_req > cfg_load > phase_req. timer_irq is ignored in IDLE.
- Load sequence:
  - Checks: cfg_divider <16 sets err_divider and leaves the state unchanged. Otherwise latch P = cfg_divider-1 and clear tick_count.
  - STOP: write addr1 = 0x0008.
  - PL: write addr2 = P[15:0].
  - PH: write addr3 = P[31:16].
  - CLR: write addr0 = 0x0000, clearing any stale timeout.
  - CTRL: write addr1 = 0x0007 (ITO, CONT, START).
  - Then go to RUN. The first write occurs in the cycle after acceptance, and the sequence takes 5 bus cycles.
- Stop sequence: STOP (addr1 = 0x0008), then CLR (addr0 = 0x0000), then IDLE.
- IRQ service (RUN with timer_irq=1): go to ACK. In ACK, write addr0 = 0x0000, pulse tick, and increment tick_count (0xFFFF wraps to 0x0000). Return to RUN. timer_irq is low again on the first RUN cycle.
- Phase read: record the return state (IDLE or RUN), then:
  - SNAP: write addr4 = 0x0000.
  - RDL: read addr4.
  - RDH: capture phase[15:0] from avm_readdata; read addr5.
  - CAP: capture phase[31:16]; pulse phase_valid; return to the recorded state.
  - Total: 4 cycles from acceptance to return.
  - An irq arriving during a phase read is serviced on return to RUN. The worst-case ack delay of 5 cycles is why the divider minimum is 16.
- Tick period equals cfg_divider clk cycles: the timer loads P and counts down through zero.
- AUTO_START=1: the first cycle after reset deasserts acts as cfg_load with DEFAULT_DIVIDER.
- Reset mid-sequence aborts immediately to IDLE with the bus idle. The timer is expected to be reset together with this block.

Test Plan:
1. Reset, AUTO_START=0, cfg_load pulse with cfg_divider=100 -> bus writes in order (1,0x0008), (2,0x0063), (3,0x0000), (0,0x0000), (1,0x0007). busy for 5 cycles, then running=1. Ticks occur every 100 cycles. tick_count reads 3 after 3 ticks.
2. Running with divider=20 and phase_req -> writes addr4, reads addr4 then addr5. phase_valid pulses 4 cycles after the request; phase lies in 0..19 and matches a reference model counter. Timer irq raised mid-read -> the tick is still delivered with no lost ticks over 50 periods.
3. stop_req and cfg_load in the same cycle while RUN -> stop sequence only: (1,0x0008), (0,0x0000). Ends in IDLE with running=0 and no further ticks.
4. cfg_load with cfg_divider=15 -> err_divider=1, no bus activity, state unchanged. A later cfg_load with divider=16 is accepted; err_divider stays 1.
5. Load divider=0x0001_86A0 with tick_count preset near wrap (force 65534 ticks) -> period writes 0x869F and 0x0001. tick_count sequence reads 0xFFFE, 0xFFFF, 0x0000.
6. Assert reset during the PH state -> next cycle: IDLE, bus idle, tick_count=0. With AUTO_START=1 the load sequence restarts with P=999999 (0x000F423F).

Source files
------------

// File: rtl/audio_timer_sched.sv
// Avalon-MM sequencer for the audio interval timer: programs the period,
// turns timeout irqs into sample ticks, and takes atomic phase snapshots.
module audio_timer_sched #(
  parameter int unsigned DEFAULT_DIVIDER = 1000000,
  parameter bit          AUTO_START      = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cfg_divider,
  input  logic        cfg_load,
  input  logic        stop_req,
  input  logic        phase_req,
  output logic        busy,
  output logic        running,
  output logic        tick,
  output logic [15:0] tick_count,
  output logic [31:0] phase,
  output logic        phase_valid,
  output logic        err_divider,
  output logic [2:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [15:0] avm_writedata,
  input  logic [15:0] avm_readdata,
  input  logic        timer_irq
);
  typedef enum logic [3:0] {
    S_IDLE, S_RUN, S_LSTOP, S_LPL, S_LPH, S_LCLR, S_LCTRL,
    S_SSTOP, S_SCLR, S_ACK, S_SNAP, S_RDL, S_RDH, S_CAP
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] period_q, phase_q, load_div;
  logic [15:0] tick_count_q;
  logic        ret_run_q, err_q, auto_pend_q;
  logic        sample, load_req, load_ok, take_load, take_phase, in_phase;

  // The auto-start request masquerades as a cfg_load for exactly one IDLE cycle.
  assign load_req   = cfg_load | auto_pend_q;
  assign load_div   = auto_pend_q ? DEFAULT_DIVIDER : cfg_divider;
  assign load_ok    = load_div >= 32'd16;
  assign sample     = (state == S_IDLE) || (state == S_RUN && !timer_irq);
  assign take_load  = sample && !stop_req && load_req;
  assign take_phase = sample && !stop_req && !load_req && phase_req;
  assign in_phase   = state inside {S_SNAP, S_RDL, S_RDH, S_CAP};

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_RUN: begin
        if (state == S_RUN && timer_irq) state_nxt = S_ACK;
        else if (stop_req)               state_nxt = S_SSTOP;
        else if (load_req)               state_nxt = load_ok ? S_LSTOP : state;
        else if (phase_req)              state_nxt = S_SNAP;
      end
      S_LSTOP: state_nxt = S_LPL;
      S_LPL:   state_nxt = S_LPH;
      S_LPH:   state_nxt = S_LCLR;
      S_LCLR:  state_nxt = S_LCTRL;
      S_LCTRL: state_nxt = S_RUN;
      S_SSTOP: state_nxt = S_SCLR;
      S_SCLR:  state_nxt = S_IDLE;
      S_ACK:   state_nxt = S_RUN;
      S_SNAP:  state_nxt = S_RDL;
      S_RDL:   state_nxt = S_RDH;
      S_RDH:   state_nxt = S_CAP;
      S_CAP:   state_nxt = ret_run_q ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_address    = '0;
    avm_writedata  = '0;
    tick           = 1'b0;
    phase_valid    = 1'b0;
    unique case (state)
      S_LSTOP, S_SSTOP: begin
        avm_chipselect = 1'b1; avm_write_n = 1'b0; avm_address = 3'd1; avm_writedata = 16'h0008;
      end
      S_LPL: begin
        avm_chipselect = 1'b1; avm_write_n = 1'b0; avm_address = 3'd2; avm_writedata = period_q[15:0];
      end
      S_LPH: begin
        avm_chipselect = 1'b1; avm_write_n = 1'b0; avm_address = 3'd3; avm_writedata = period_q[31:16];
      end
      S_LCLR, S_SCLR: begin
        avm_chipselect = 1'b1; avm_write_n = 1'b0; avm_address = 3'd0;
      end
      S_ACK: begin
        avm_chipselect = 1'b1; avm_write_n = 1'b0; avm_address = 3'd0; tick = 1'b1;
      end
      S_LCTRL: begin
        avm_chipselect = 1'b1; avm_write_n = 1'b0; avm_address = 3'd1; avm_writedata = 16'h0007;
      end
      S_SNAP: begin
        avm_chipselect = 1'b1; avm_write_n = 1'b0; avm_address = 3'd4;
      end
      S_RDL: begin
        avm_chipselect = 1'b1; avm_address = 3'd4;
      end
      S_RDH: begin
        avm_chipselect = 1'b1; avm_address = 3'd5;
      end
      S_CAP:   phase_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      period_q     <= '0;
      phase_q      <= '0;
      tick_count_q <= '0;
      ret_run_q    <= 1'b0;
      err_q        <= 1'b0;
      auto_pend_q  <= AUTO_START;
    end else begin
      auto_pend_q <= 1'b0;
      if (take_load) begin
        if (load_ok) begin
          period_q     <= load_div - 32'd1;
          tick_count_q <= '0;
        end else begin
          err_q <= 1'b1;
        end
      end
      if (take_phase)      ret_run_q          <= (state == S_RUN);
      if (state == S_ACK)  tick_count_q       <= tick_count_q + 16'd1;
      if (state == S_RDH)  phase_q[15:0]      <= avm_readdata;
      if (state == S_CAP)  phase_q[31:16]     <= avm_readdata;
    end
  end

  // The high half is forwarded during CAP so phase is complete while phase_valid is high.
  assign phase       = (state == S_CAP) ? {avm_readdata, phase_q[15:0]} : phase_q;
  assign busy        = !(state inside {S_IDLE, S_RUN});
  assign running     = (state == S_RUN) || (in_phase && ret_run_q);
  assign tick_count  = tick_count_q;
  assign err_divider = err_q;

endmodule

// File: tb/tb_audio_timer_sched.sv
// Self-checking bench for audio_timer_sched with a behavioural interval timer.
`timescale 1ns/1ps
module tb_audio_timer_sched;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, reset2 = 1'b1;
  logic [31:0] cfg_divider = '0;
  logic        cfg_load = 1'b0, stop_req = 1'b0, phase_req = 1'b0;
  logic        busy, running, tick, phase_valid, err_divider;
  logic [15:0] tick_count, avm_writedata, avm_readdata;
  logic [31:0] phase;
  logic [2:0]  avm_address;
  logic        avm_chipselect, avm_write_n, timer_irq;

  logic        a_busy, a_running, a_tick, a_phase_valid, a_err, a_cs, a_wn;
  logic [15:0] a_tick_count, a_wd;
  logic [31:0] a_phase;
  logic [2:0]  a_address;

  int unsigned n_tests = 0, n_fail = 0;

  audio_timer_sched #(.DEFAULT_DIVIDER(100), .AUTO_START(1'b0)) dut (
    .clk(clk), .reset(reset), .cfg_divider(cfg_divider), .cfg_load(cfg_load),
    .stop_req(stop_req), .phase_req(phase_req), .busy(busy), .running(running),
    .tick(tick), .tick_count(tick_count), .phase(phase), .phase_valid(phase_valid),
    .err_divider(err_divider), .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write_n(avm_write_n), .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .timer_irq(timer_irq));

  audio_timer_sched #(.DEFAULT_DIVIDER(1000000), .AUTO_START(1'b1)) dut_auto (
    .clk(clk), .reset(reset2), .cfg_divider(32'd0), .cfg_load(1'b0),
    .stop_req(1'b0), .phase_req(1'b0), .busy(a_busy), .running(a_running),
    .tick(a_tick), .tick_count(a_tick_count), .phase(a_phase), .phase_valid(a_phase_valid),
    .err_divider(a_err), .avm_address(a_address), .avm_chipselect(a_cs),
    .avm_write_n(a_wn), .avm_writedata(a_wd), .avm_readdata(16'h0000), .timer_irq(1'b0));

  // Behavioural interval timer: counts P..0, reloads and sets TO on wrap.
  logic [15:0] t_ctrl;
  logic [31:0] t_period, t_cnt, t_snap;
  logic        t_to, t_run;
  int unsigned t_timeouts = 0;
  always @(posedge clk) begin
    if (reset) begin
      t_ctrl <= '0; t_period <= '0; t_cnt <= '0; t_snap <= '0;
      t_to <= 1'b0; t_run <= 1'b0; avm_readdata <= '0;
    end else begin
      if (t_run) begin
        if (t_cnt == 0) begin t_cnt <= t_period; t_to <= 1'b1; t_timeouts <= t_timeouts + 1; end
        else t_cnt <= t_cnt - 1;
      end
      avm_readdata <= '0;
      if (avm_chipselect && !avm_write_n) begin
        case (avm_address)
          3'd0: t_to <= 1'b0;
          3'd1: begin
            t_ctrl <= avm_writedata;
            if (avm_writedata[3]) t_run <= 1'b0;
            else if (avm_writedata[2]) t_run <= 1'b1;
          end
          3'd2: begin t_period[15:0] <= avm_writedata; t_cnt <= {t_period[31:16], avm_writedata}; end
          3'd3: begin t_period[31:16] <= avm_writedata; t_cnt <= {avm_writedata, t_period[15:0]}; end
          3'd4, 3'd5: t_snap <= t_cnt;
          default: ;
        endcase
      end else if (avm_chipselect) begin
        case (avm_address)
          3'd0: avm_readdata <= {15'd0, t_to};
          3'd1: avm_readdata <= t_ctrl;
          3'd4: avm_readdata <= t_snap[15:0];
          3'd5: avm_readdata <= t_snap[31:16];
          default: avm_readdata <= '0;
        endcase
      end
    end
  end
  assign timer_irq = t_to & t_ctrl[0];

  typedef struct packed { logic [2:0] a; logic [15:0] d; logic [31:0] c; } bus_t;
  bus_t        wq[$], aq[$];
  logic [2:0]  rq[$];
  logic [31:0] tq[$];
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!reset) begin
      if (avm_chipselect && !avm_write_n) wq.push_back(bus_t'{a: avm_address, d: avm_writedata, c: cyc});
      if (avm_chipselect && avm_write_n)  rq.push_back(avm_address);
      if (tick) tq.push_back(cyc);
    end
    if (!reset2 && a_cs && !a_wn) aq.push_back(bus_t'{a: a_address, d: a_wd, c: cyc});
  end

  // Expected k-th write of the load sequence for a given divider.
  function automatic logic [18:0] load_write(input logic [31:0] d, input int k);
    logic [31:0] p;
    p = d - 32'd1;
    case (k)
      0:       return {3'd1, 16'h0008};
      1:       return {3'd2, p[15:0]};
      2:       return {3'd3, p[31:16]};
      3:       return {3'd0, 16'h0000};
      default: return {3'd1, 16'h0007};
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!busy && !timer_irq) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic do_load(input logic [31:0] d, output int unsigned c0);
    cfg_divider = d; cfg_load = 1'b1; c0 = cyc;
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  task automatic wait_ticks(input int unsigned n, input int unsigned budget);
    for (int unsigned i = 0; i < budget && tq.size() < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++; if ({busy, running, tick, phase_valid, err_divider, avm_chipselect, avm_write_n} !== 7'b0000001) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000001", {busy, running, tick, phase_valid, err_divider, avm_chipselect, avm_write_n}); end
    n_tests++; if (tick_count !== 16'd0) begin n_fail++; $display("FAIL reset_tick_count: got %h want 0", tick_count); end
    n_tests++; if (phase !== 32'd0) begin n_fail++; $display("FAIL reset_phase: got %h want 0", phase); end
    n_tests++; if ({avm_address, avm_writedata} !== 19'd0) begin n_fail++; $display("FAIL reset_bus: got %h want 0", {avm_address, avm_writedata}); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load();
    int unsigned c0;
    logic [18:0] e;
    wq.delete(); tq.delete();
    do_load(32'd100, c0);
    for (int k = 1; k <= 5; k++) begin
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL load_busy c%0d: got %b want 1", k, busy); end
      @(negedge clk);
    end
    n_tests++; if ({busy, running} !== 2'b01) begin n_fail++; $display("FAIL load_running: got %b want 01", {busy, running}); end
    n_tests++; if (wq.size() != 5) begin n_fail++; $display("FAIL load_nwrites: got %0d want 5", wq.size()); end
    for (int k = 0; k < 5 && k < wq.size(); k++) begin
      e = load_write(32'd100, k);
      n_tests++; if (wq[k].a !== e[18:16] || wq[k].d !== e[15:0] || wq[k].c !== c0 + 1 + k) begin
        n_fail++; $display("FAIL load_write%0d: got %0d/%h@%0d want %0d/%h@%0d", k, wq[k].a, wq[k].d, wq[k].c, e[18:16], e[15:0], c0 + 1 + k); end
    end
    wait_ticks(3, 400);
    n_tests++; if (tq.size() != 3) begin n_fail++; $display("FAIL load_ticks: got %0d want 3", tq.size()); end
    @(negedge clk);
    n_tests++; if (tick_count !== 16'd3) begin n_fail++; $display("FAIL load_tick_count: got %0d want 3", tick_count); end
    for (int i = 0; i + 1 < tq.size(); i++) begin
      n_tests++; if (tq[i+1] - tq[i] != 100) begin n_fail++; $display("FAIL load_period%0d: got %0d want 100", i, tq[i+1] - tq[i]); end
    end
  endtask

  task automatic test_random_loads();
    int unsigned c0;
    logic [31:0] d;
    logic [18:0] e;
    logic ok;
    repeat (3) begin
      d = $urandom_range(16, 64);
      wait_ready(ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL rnd_ready: got busy want idle/run"); end
      wq.delete(); tq.delete();
      do_load(d, c0);
      n_tests++; if (tick_count !== 16'd0) begin n_fail++; $display("FAIL rnd_clear: got %0d want 0", tick_count); end
      step(5);
      n_tests++; if (wq.size() != 5) begin n_fail++; $display("FAIL rnd_nwrites: got %0d want 5", wq.size()); end
      for (int k = 0; k < 5 && k < wq.size(); k++) begin
        e = load_write(d, k);
        n_tests++; if (wq[k].a !== e[18:16] || wq[k].d !== e[15:0]) begin
          n_fail++; $display("FAIL rnd_write%0d: got %0d/%h want %0d/%h (div %0d)", k, wq[k].a, wq[k].d, e[18:16], e[15:0], d); end
      end
      wait_ticks(3, 4 * d + 20);
      n_tests++; if (tq.size() != 3) begin n_fail++; $display("FAIL rnd_ticks: got %0d want 3", tq.size()); end
      for (int i = 0; i + 1 < tq.size(); i++) begin
        n_tests++; if (tq[i+1] - tq[i] != d) begin n_fail++; $display("FAIL rnd_period: got %0d want %0d", tq[i+1] - tq[i], d); end
      end
    end
  endtask

  task automatic test_phase();
    int unsigned c0, base, start, nreq;
    logic ok;
    wait_ready(ok);
    do_load(32'd20, c0);
    step(5);
    base = t_timeouts; tq.delete(); start = cyc; nreq = 0;
    while (cyc < start + 1000) begin
      int unsigned k;
      logic align;
      k = $urandom_range(0, 4);
      align = ($urandom_range(0, 1) == 1);
      step($urandom_range(0, 12));
      for (int i = 0; i < 60; i++) begin
        if (!busy && !timer_irq && (!align || t_cnt == k)) break;
        @(negedge clk);
      end
      if (busy || timer_irq) continue;
      wq.delete(); rq.delete();
      phase_req = 1'b1; c0 = cyc;
      @(negedge clk);
      phase_req = 1'b0; nreq++;
      for (int j = 1; j < 4; j++) begin
        n_tests++; if ({phase_valid, running} !== 2'b01) begin n_fail++; $display("FAIL phase_wait c%0d: got %b want 01", j, {phase_valid, running}); end
        @(negedge clk);
      end
      n_tests++; if ({phase_valid, running} !== 2'b11) begin n_fail++; $display("FAIL phase_valid: got %b want 11", {phase_valid, running}); end
      n_tests++; if (phase !== t_snap || phase > 32'd19) begin n_fail++; $display("FAIL phase_value: got %0d want %0d (<=19)", phase, t_snap); end
      n_tests++; if (wq.size() != 1 || wq[0].a !== 3'd4 || wq[0].d !== 16'h0 || wq[0].c !== c0 + 1) begin
        n_fail++; $display("FAIL phase_snap_write: got n=%0d want one addr4 write at %0d", wq.size(), c0 + 1); end
      n_tests++; if (rq.size() != 2 || rq[0] !== 3'd4 || rq[1] !== 3'd5) begin
        n_fail++; $display("FAIL phase_reads: got n=%0d want reads 4,5", rq.size()); end
    end
    wait_ready(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL phase_settle: got busy want idle/run"); end
    n_tests++; if (tq.size() != t_timeouts - base) begin n_fail++; $display("FAIL phase_no_lost_ticks: got %0d want %0d", tq.size(), t_timeouts - base); end
    n_tests++; if (tick_count !== 16'(t_timeouts - base)) begin n_fail++; $display("FAIL phase_tick_count: got %0d want %0d", tick_count, t_timeouts - base); end
    n_tests++; if (tq.size() < 45 || nreq < 10) begin n_fail++; $display("FAIL phase_activity: got ticks=%0d reqs=%0d want >=45, >=10", tq.size(), nreq); end
  endtask

  task automatic test_stop_priority();
    int unsigned c0;
    logic ok;
    wait_ready(ok);
    wq.delete(); tq.delete();
    stop_req = 1'b1; cfg_load = 1'b1; cfg_divider = 32'd40; c0 = cyc;
    @(negedge clk);
    stop_req = 1'b0; cfg_load = 1'b0;
    step(2);
    n_tests++; if ({busy, running} !== 2'b00) begin n_fail++; $display("FAIL stop_state: got %b want 00", {busy, running}); end
    n_tests++; if (wq.size() != 2) begin n_fail++; $display("FAIL stop_nwrites: got %0d want 2", wq.size()); end
    else begin
      n_tests++; if (wq[0].a !== 3'd1 || wq[0].d !== 16'h0008 || wq[0].c !== c0 + 1) begin n_fail++; $display("FAIL stop_w0: got %0d/%h want 1/0008", wq[0].a, wq[0].d); end
      n_tests++; if (wq[1].a !== 3'd0 || wq[1].d !== 16'h0000 || wq[1].c !== c0 + 2) begin n_fail++; $display("FAIL stop_w1: got %0d/%h want 0/0000", wq[1].a, wq[1].d); end
    end
    step(100);
    n_tests++; if (tq.size() != 0 || running !== 1'b0) begin n_fail++; $display("FAIL stop_quiet: got ticks=%0d running=%b want 0,0", tq.size(), running); end
  endtask

  task automatic test_err();
    int unsigned c0;
    logic [15:0] tc;
    logic ok;
    wq.delete();
    do_load(32'd15, c0);
    n_tests++; if ({err_divider, busy, running} !== 3'b100) begin n_fail++; $display("FAIL err_set: got %b want 100", {err_divider, busy, running}); end
    step(4);
    n_tests++; if (wq.size() != 0) begin n_fail++; $display("FAIL err_nobus: got %0d writes want 0", wq.size()); end
    tq.delete();
    do_load(32'd16, c0);
    step(5);
    n_tests++; if ({err_divider, running} !== 2'b11) begin n_fail++; $display("FAIL err_accept16: got %b want 11", {err_divider, running}); end
    n_tests++; if (wq.size() != 5 || wq[1].d !== 16'h000F) begin n_fail++; $display("FAIL err_period16: got n=%0d pl=%h want 5, 000F", wq.size(), wq[1].d); end
    wait_ticks(2, 80);
    n_tests++; if (tq.size() != 2 || tq[1] - tq[0] != 16) begin n_fail++; $display("FAIL err_tick16: got n=%0d want 2 ticks 16 apart", tq.size()); end
    wait_ready(ok);
    tc = tick_count;
    do_load(32'd5, c0);
    n_tests++; if ({busy, running} !== 2'b01 || tick_count !== tc) begin n_fail++; $display("FAIL err_run_reject: got %b/%0d want 01/%0d", {busy, running}, tick_count, tc); end
  endtask

  task automatic test_wrap();
    int unsigned c0;
    logic [15:0] v;
    logic ok;
    wait_ready(ok);
    wq.delete();
    do_load(32'h0001_86A0, c0);
    step(5);
    n_tests++; if (wq.size() != 5 || wq[1].d !== 16'h869F || wq[2].d !== 16'h0001) begin
      n_fail++; $display("FAIL wrap_period: got n=%0d %h/%h want 5 869F/0001", wq.size(), wq[1].d, wq[2].d); end
    wait_ready(ok);
    do_load(32'd20, c0);
    step(5);
    force dut.tick_count_q = 16'hFFFD;
    @(negedge clk);
    release dut.tick_count_q;
    v = 16'hFFFD;
    tq.delete();
    for (int i = 1; i <= 3; i++) begin
      v = v + 16'd1;
      wait_ticks(i, 60);
      @(negedge clk);
      n_tests++; if (tick_count !== v) begin n_fail++; $display("FAIL wrap_count%0d: got %h want %h", i, tick_count, v); end
    end
  endtask

  task automatic test_reset_mid();
    int unsigned c0;
    logic [18:0] e;
    logic ok;
    wait_ready(ok);
    do_load(32'd30, c0);
    step(2);
    n_tests++; if ({avm_chipselect, avm_write_n, avm_address} !== 5'b10011) begin n_fail++; $display("FAIL mid_in_ph: got %b want 10011", {avm_chipselect, avm_write_n, avm_address}); end
    reset = 1'b1;
    @(negedge clk);
    n_tests++; if ({busy, running, avm_chipselect, avm_write_n, err_divider} !== 5'b00010 || {avm_address, avm_writedata} !== 19'd0) begin
      n_fail++; $display("FAIL mid_abort: got %b/%h want 00010/0", {busy, running, avm_chipselect, avm_write_n, err_divider}, {avm_address, avm_writedata}); end
    n_tests++; if (tick_count !== 16'd0 || phase !== 32'd0) begin n_fail++; $display("FAIL mid_regs: got %h/%h want 0/0", tick_count, phase); end
    reset = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      aq.delete();
      reset2 = 1'b0; c0 = cyc;
      if (pass == 0) begin
        step(6);
        n_tests++; if (aq.size() != 5) begin n_fail++; $display("FAIL auto_nwrites: got %0d want 5", aq.size()); end
        for (int k = 0; k < 5 && k < aq.size(); k++) begin
          e = load_write(32'd1000000, k);
          n_tests++; if (aq[k].a !== e[18:16] || aq[k].d !== e[15:0] || aq[k].c !== c0 + 1 + k) begin
            n_fail++; $display("FAIL auto_write%0d: got %0d/%h@%0d want %0d/%h@%0d", k, aq[k].a, aq[k].d, aq[k].c, e[18:16], e[15:0], c0 + 1 + k); end
        end
        reset2 = 1'b1;
        step(2);
      end else begin
        step(3);
        n_tests++; if ({a_cs, a_wn, a_address, a_wd} !== {2'b10, 3'd3, 16'h000F}) begin
          n_fail++; $display("FAIL auto_in_ph: got %b/%h want 10011/000F", {a_cs, a_wn, a_address}, a_wd); end
        reset2 = 1'b1;
        @(negedge clk);
        n_tests++; if ({a_busy, a_running, a_cs, a_wn, a_tick, a_phase_valid, a_err} !== 7'b0001000 || a_tick_count !== 16'd0 || {a_address, a_wd} !== 19'd0 || a_phase !== 32'd0) begin
          n_fail++; $display("FAIL auto_abort: got %b/%h/%h want 0001000/0/0", {a_busy, a_running, a_cs, a_wn, a_tick, a_phase_valid, a_err}, a_tick_count, {a_address, a_wd}); end
        aq.delete();
        reset2 = 1'b0; c0 = cyc;
        step(6);
        n_tests++; if (aq.size() != 5) begin n_fail++; $display("FAIL auto_restart_n: got %0d want 5", aq.size()); end
        for (int k = 0; k < 5 && k < aq.size(); k++) begin
          e = load_write(32'd1000000, k);
          n_tests++; if (aq[k].a !== e[18:16] || aq[k].d !== e[15:0] || aq[k].c !== c0 + 1 + k) begin
            n_fail++; $display("FAIL auto_restart%0d: got %0d/%h@%0d want %0d/%h@%0d", k, aq[k].a, aq[k].d, aq[k].c, e[18:16], e[15:0], c0 + 1 + k); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_random_loads();
    test_phase();
    test_stop_priority();
    test_err();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #(1_000_000);
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
